// File: rtl/uart_pkg.sv
// Shared state encodings and default bit timing for the uart_port slice.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 16;

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

endpackage

// File: rtl/uart_tx_ser.sv
// 8N1 transmit shifter: takes a byte on load_i and serialises it LSB first.
module uart_tx_ser
    import uart_pkg::*;
#(
    parameter int unsigned ClksPerBit = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       tx_o
);

    localparam int unsigned CntW = $clog2(ClksPerBit);
    localparam logic [CntW-1:0] LastCnt = CntW'(ClksPerBit - 1);

    tx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            bit_end;

    assign bit_end = (cnt_q == LastCnt);
    // Ready in the last stop-bit cycle too, so a queued byte follows with no idle gap.
    assign ready_o = (state_q == TxIdle) || ((state_q == TxStop) && bit_end);
    assign tx_o    = tx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        if (state_q != TxIdle) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end
        case (state_q)
            TxIdle: begin
                if (load_i) begin
                    state_d = TxStart;
                    cnt_d   = '0;
                    shift_d = data_i;
                    tx_d    = 1'b0;
                end
            end
            TxStart: begin
                if (bit_end) begin
                    state_d = TxData;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            TxData: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = TxStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            TxStop: begin
                if (bit_end) begin
                    if (load_i) begin
                        state_d = TxStart;
                        shift_d = data_i;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = TxIdle;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: state_d = TxIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= TxIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/uart_port.sv
// CPU-facing 8N1 UART: double-buffered transmit path and single-byte receive
// holding register with sticky overrun and framing-error flags.
module uart_port
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] data_in,
    input  logic       rd_en,
    output logic [7:0] data_out,
    output logic       di_ready,
    output logic       do_ready,
    output logic       rx_overrun,
    output logic       rx_frame_err,
    input  logic       serial_rx,
    output logic       serial_tx
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);

    // Transmit holding register. hold_armed_q lags hold_full_q by one cycle so the
    // shifter picks a fresh byte up two edges after the write.
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic       hold_armed_q, hold_armed_d;
    logic       tx_ready, tx_load;

    assign tx_load  = hold_armed_q & tx_ready;
    assign do_ready = ~hold_full_q;

    always_comb begin
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        hold_armed_d = hold_full_q;
        if (tx_load) begin
            hold_full_d  = 1'b0;
            hold_armed_d = 1'b0;
        end
        if (wr_en && !hold_full_q) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end
    end

    uart_tx_ser #(
        .ClksPerBit(CLKS_PER_BIT)
    ) u_tx_ser (
        .clk_i  (clk),
        .reset_i(reset),
        .load_i (tx_load),
        .data_i (hold_q),
        .ready_o(tx_ready),
        .tx_o   (serial_tx)
    );

    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_done, rx_bad;

    // Falling-edge start detect: a line held low after a bad stop bit cannot re-trigger.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        rx_bad     = 1'b0;
        case (rx_state_q)
            RxIdle: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = '0;
                end
            end
            RxStart: begin
                if (rx_cnt_q == HalfCnt) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxData: begin
                if (rx_cnt_q == LastCnt) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == LastCnt) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxIdle;
                    rx_done    = rx_sync_q;
                    rx_bad     = ~rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    logic [7:0] data_out_q, data_out_d;
    logic       di_ready_q, di_ready_d;
    logic       overrun_q, overrun_d;
    logic       frame_err_q, frame_err_d;
    logic       rd_ack;

    always_comb begin
        data_out_d  = data_out_q;
        di_ready_d  = di_ready_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        rd_ack      = rd_en && di_ready_q;
        if (rd_ack) begin
            di_ready_d  = 1'b0;
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (rx_done) begin
            if (!di_ready_q || rd_ack) begin
                data_out_d = rx_shift_q;
                di_ready_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (rx_bad) begin
            frame_err_d = 1'b1;
        end
    end

    assign data_out     = data_out_q;
    assign di_ready     = di_ready_q;
    assign rx_overrun   = overrun_q;
    assign rx_frame_err = frame_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            hold_armed_q <= 1'b0;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RxIdle;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            data_out_q   <= '0;
            di_ready_q   <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            hold_armed_q <= hold_armed_d;
            rx_meta_q    <= serial_rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            data_out_q   <= data_out_d;
            di_ready_q   <= di_ready_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
        end
    end

endmodule
